// File: rtl/id_operand_stage_if.sv
// rtl/id_operand_stage_if.sv - decode-side and EX-side handshake bundle for the ID/EX operand stage
interface id_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic              in_re1;
  logic              in_re2;
  logic [REG_AW-1:0] in_raddr1;
  logic [REG_AW-1:0] in_raddr2;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [REG_AW-1:0] in_rd;
  logic              in_rd_e;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_op1;
  logic [XLEN-1:0]   out_op2;
  logic [XLEN-1:0]   out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [REG_AW-1:0] out_rd;
  logic              out_rd_e;

  modport master (
    output in_valid, in_pc, in_re1, in_re2, in_raddr1, in_raddr2,
           in_imm, in_ctrl, in_rd, in_rd_e, out_ready,
    input  in_ready, out_valid, out_pc, out_op1, out_op2, out_imm,
           out_ctrl, out_rd, out_rd_e
  );

  modport slave (
    input  in_valid, in_pc, in_re1, in_re2, in_raddr1, in_raddr2,
           in_imm, in_ctrl, in_rd, in_rd_e, out_ready,
    output in_ready, out_valid, out_pc, out_op1, out_op2, out_imm,
           out_ctrl, out_rd, out_rd_e
  );
endinterface

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - ID/EX operand resolution with forwarding, load-use stall and flush
// Optional ID_PERF_CNT_EN adds perf_stall/perf_flush event counters.
module id_operand_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  id_operand_stage_if.slave         bus,
  input  logic [XLEN-1:0]           rdata1,
  input  logic [XLEN-1:0]           rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_pend,
  input  logic                      flush,
  output logic                      stall_o
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall,
  output logic [31:0]               perf_flush
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rd_e_q, rd_e_d;

  logic [XLEN:0]     res1, res2;
  logic [XLEN-1:0]   op1_val, op2_val;
  logic              haz1, haz2;
  logic              hazard;
  logic              in_ready_c;
  logic              fire;

  // Returns {pending, value}; the lowest-index (youngest) matching writer wins.
  function automatic logic [XLEN:0] fwd_resolve(
    input logic [REG_AW-1:0]         raddr,
    input logic [XLEN-1:0]           rf_data,
    input logic [NUM_FWD-1:0]        we,
    input logic [NUM_FWD*REG_AW-1:0] waddr,
    input logic [NUM_FWD*XLEN-1:0]   wdata,
    input logic [NUM_FWD-1:0]        pend
  );
    logic          found;
    logic [XLEN:0] res;
    found = 1'b0;
    res   = {1'b0, rf_data};
    if (raddr == '0) begin
      res = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && we[i] && (waddr[i*REG_AW +: REG_AW] == raddr)) begin
          found = 1'b1;
          res   = {pend[i], wdata[i*XLEN +: XLEN]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    res1    = fwd_resolve(bus.in_raddr1, rdata1, fwd_we, fwd_waddr, fwd_wdata, fwd_pend);
    res2    = fwd_resolve(bus.in_raddr2, rdata2, fwd_we, fwd_waddr, fwd_wdata, fwd_pend);
    op1_val = '0;
    haz1    = 1'b0;
    op2_val = bus.in_imm;
    haz2    = 1'b0;
    if (bus.in_re1) begin
      op1_val = res1[XLEN-1:0];
      haz1    = res1[XLEN];
    end
    if (bus.in_re2) begin
      op2_val = res2[XLEN-1:0];
      haz2    = res2[XLEN];
    end
  end

  assign hazard     = bus.in_valid && (haz1 || haz2);
  assign stall_o    = hazard && !flush;
  assign in_ready_c = !flush && !hazard && ((state_q == S_EMPTY) || bus.out_ready);
  assign fire       = bus.in_valid && in_ready_c;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    rd_e_d  = rd_e_q;
    // Data registers only move on an accepted instruction; bubbles and flushes just drop valid.
    if (fire) begin
      pc_d   = bus.in_pc;
      op1_d  = op1_val;
      op2_d  = op2_val;
      imm_d  = bus.in_imm;
      ctrl_d = bus.in_ctrl;
      rd_d   = bus.in_rd;
      rd_e_d = bus.in_rd_e;
    end
    if (flush) begin
      state_d = S_EMPTY;
    end else if (fire) begin
      state_d = S_FULL;
    end else if ((state_q == S_FULL) && bus.out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      pc_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      rd_e_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      rd_e_q  <= rd_e_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == S_FULL);
  assign bus.out_pc    = pc_q;
  assign bus.out_op1   = op1_q;
  assign bus.out_op2   = op2_q;
  assign bus.out_imm   = imm_q;
  assign bus.out_ctrl  = ctrl_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_rd_e  = rd_e_q;

`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_o) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (flush && ((state_q == S_FULL) || bus.in_valid)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - directed and randomized checks of id_operand_stage against a reference model
// Optional ID_PERF_CNT_EN also checks the perf counters.
module tb_id_operand_stage;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NF   = 2;
  localparam int CW   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] rdata1, rdata2;
  logic [NF-1:0]   fwd_we, fwd_pend;
  logic [NF*AW-1:0]   fwd_waddr;
  logic [NF*XLEN-1:0] fwd_wdata;
  logic            flush;
  logic            stall_o;
`ifdef ID_PERF_CNT_EN
  logic [31:0]     perf_stall, perf_flush;
`endif

  id_operand_stage_if #(.XLEN(XLEN), .REG_AW(AW), .CTRL_W(CW)) bus ();

  id_operand_stage #(.XLEN(XLEN), .REG_AW(AW), .NUM_FWD(NF), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .fwd_we    (fwd_we),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .fwd_pend  (fwd_pend),
    .flush     (flush),
    .stall_o   (stall_o)
`ifdef ID_PERF_CNT_EN
    ,
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // Forwarding sources as plain arrays; index 0 is the youngest producer.
  logic            t_we[NF];
  logic [AW-1:0]   t_addr[NF];
  logic [XLEN-1:0] t_data[NF];
  logic            t_pend[NF];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_comb = 1'b0;
  logic obs_stall, obs_ready;

  logic            m_valid = 1'b0;
  logic [XLEN-1:0] m_pc = '0, m_op1 = '0, m_op2 = '0, m_imm = '0;
  logic [CW-1:0]   m_ctrl = '0;
  logic [AW-1:0]   m_rd = '0;
  logic            m_rd_e = 1'b0;
  logic [31:0]     m_pstall = '0, m_pflush = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk producers oldest to youngest so the youngest match overwrites the rest.
  function automatic void ref_src(input logic re, input logic [AW-1:0] ra, input logic [XLEN-1:0] rf,
                                  input logic [XLEN-1:0] dflt, output logic [XLEN-1:0] v, output bit h);
    h = 1'b0;
    if (!re) v = dflt;
    else if (ra == '0) v = '0;
    else begin
      v = rf;
      for (int i = NF - 1; i >= 0; i--) begin
        if (t_we[i] && t_addr[i] == ra) begin
          v = t_data[i];
          h = t_pend[i];
        end
      end
    end
  endfunction

  task automatic apply();
    for (int i = 0; i < NF; i++) begin
      fwd_we[i]              = t_we[i];
      fwd_pend[i]            = t_pend[i];
      fwd_waddr[i*AW +: AW]  = t_addr[i];
      fwd_wdata[i*XLEN +: XLEN] = t_data[i];
    end
  endtask

  task automatic set_idle();
    bus.in_valid = 0; bus.in_pc = '0; bus.in_re1 = 0; bus.in_re2 = 0;
    bus.in_raddr1 = '0; bus.in_raddr2 = '0; bus.in_imm = '0; bus.in_ctrl = '0;
    bus.in_rd = '0; bus.in_rd_e = 0; bus.out_ready = 1; flush = 0;
    rdata1 = '0; rdata2 = '0;
    for (int i = 0; i < NF; i++) begin
      t_we[i] = 0; t_addr[i] = '0; t_data[i] = '0; t_pend[i] = 0;
    end
  endtask

  task automatic rand_inputs();
    bus.in_valid  = ($urandom_range(0, 3) != 0);
    bus.in_pc     = $urandom;
    bus.in_re1    = ($urandom_range(0, 4) != 0);
    bus.in_re2    = ($urandom_range(0, 4) != 0);
    bus.in_raddr1 = AW'($urandom_range(0, 7));
    bus.in_raddr2 = AW'($urandom_range(0, 7));
    bus.in_imm    = $urandom;
    bus.in_ctrl   = CW'($urandom);
    bus.in_rd     = AW'($urandom);
    bus.in_rd_e   = 1'($urandom);
    bus.out_ready = ($urandom_range(0, 3) != 0);
    flush         = ($urandom_range(0, 9) == 0);
    rdata1        = $urandom;
    rdata2        = $urandom;
    rst           = ($urandom_range(0, 63) == 0);
    for (int i = 0; i < NF; i++) begin
      t_we[i]   = 1'($urandom);
      t_addr[i] = AW'($urandom_range(0, 7));
      t_data[i] = $urandom;
      t_pend[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic cycle();
    logic [XLEN-1:0] e1, e2;
    bit h1, h2, hz, st, rdy, fr;
    apply();
    @(negedge clk);
    ref_src(bus.in_re1, bus.in_raddr1, rdata1, '0, e1, h1);
    ref_src(bus.in_re2, bus.in_raddr2, rdata2, bus.in_imm, e2, h2);
    hz  = bus.in_valid && (h1 || h2);
    st  = hz && !flush;
    rdy = !flush && !hz && (!m_valid || bus.out_ready);
    fr  = bus.in_valid && rdy;
    obs_stall = stall_o;
    obs_ready = bus.in_ready;
    if (chk_comb) begin
      check("stall_o", obs_stall, st);
      check("in_ready", obs_ready, rdy);
    end
    if (rst) begin
      m_valid = 0; m_pc = '0; m_op1 = '0; m_op2 = '0; m_imm = '0;
      m_ctrl = '0; m_rd = '0; m_rd_e = 0; m_pstall = '0; m_pflush = '0;
    end else begin
      if (st) m_pstall = m_pstall + 32'd1;
      if (flush && (m_valid || bus.in_valid)) m_pflush = m_pflush + 32'd1;
      if (fr) begin
        m_pc = bus.in_pc; m_op1 = e1; m_op2 = e2; m_imm = bus.in_imm;
        m_ctrl = bus.in_ctrl; m_rd = bus.in_rd; m_rd_e = bus.in_rd_e;
      end
      if (flush) m_valid = 0;
      else if (fr) m_valid = 1;
      else if (bus.out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid, m_valid);
    check("out_pc", bus.out_pc, m_pc);
    check("out_op1", bus.out_op1, m_op1);
    check("out_op2", bus.out_op2, m_op2);
    check("out_imm", bus.out_imm, m_imm);
    check("out_ctrl", bus.out_ctrl, m_ctrl);
    check("out_rd", bus.out_rd, m_rd);
    check("out_rd_e", bus.out_rd_e, m_rd_e);
`ifdef ID_PERF_CNT_EN
    check("perf_stall", perf_stall, m_pstall);
    check("perf_flush", perf_flush, m_pflush);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst = 1;
    cycle();
    chk_comb = 1;
    rst = 0;
    check("rst_valid", bus.out_valid, 0);
    check("rst_op1", bus.out_op1, 0);

    // No-hazard pipe
    bus.in_valid = 1; bus.in_re1 = 1; bus.in_re2 = 1;
    bus.in_raddr1 = 3; bus.in_raddr2 = 4; rdata1 = 32'h11; rdata2 = 32'h22;
    for (int c = 0; c < 4; c++) begin
      bus.in_pc = 32'h100 + 32'(c * 4);
      cycle();
      check("pipe_op1", bus.out_op1, 32'h11);
      check("pipe_op2", bus.out_op2, 32'h22);
      check("pipe_valid", bus.out_valid, 1);
      check("pipe_stall", obs_stall, 0);
    end

    // Priority forwarding
    bus.in_raddr1 = 5;
    t_we[0] = 1; t_addr[0] = 5; t_data[0] = 32'hAAAA;
    t_we[1] = 1; t_addr[1] = 5; t_data[1] = 32'hBBBB;
    cycle();
    check("prio_young", bus.out_op1, 32'hAAAA);
    t_we[0] = 0;
    cycle();
    check("prio_old", bus.out_op1, 32'hBBBB);

    // Load-use bubble then release
    set_idle();
    bus.in_valid = 1; bus.in_re2 = 1; bus.in_raddr2 = 3; rdata2 = 32'h33;
    cycle();
    bus.in_raddr2 = 7;
    t_we[0] = 1; t_addr[0] = 7; t_pend[0] = 1;
    cycle();
    check("lu_stall", obs_stall, 1);
    check("lu_ready", obs_ready, 0);
    check("lu_bubble", bus.out_valid, 0);
    t_pend[0] = 0; t_data[0] = 32'h55;
    cycle();
    check("lu_op2", bus.out_op2, 32'h55);
    check("lu_valid", bus.out_valid, 1);

    // Shadowed pending older source
    set_idle();
    bus.in_valid = 1; bus.in_re1 = 1; bus.in_raddr1 = 6;
    t_we[0] = 1; t_addr[0] = 6; t_data[0] = 32'h66;
    t_we[1] = 1; t_addr[1] = 6; t_pend[1] = 1;
    cycle();
    check("shadow_stall", obs_stall, 0);
    check("shadow_op1", bus.out_op1, 32'h66);

    // x0 and re=0
    set_idle();
    bus.in_valid = 1; bus.in_re1 = 1; bus.in_raddr1 = 0;
    t_we[0] = 1; t_addr[0] = 0; t_pend[0] = 1; t_data[0] = 32'h9;
    bus.in_re2 = 0; bus.in_imm = 32'hFFFF_F800;
    cycle();
    check("x0_op1", bus.out_op1, 0);
    check("x0_stall", obs_stall, 0);
    check("re0_op2", bus.out_op2, 32'hFFFF_F800);

    // Backpressure then flush with a hazard present
    set_idle();
    bus.in_valid = 1; bus.in_re1 = 1; bus.in_raddr1 = 3; rdata1 = 32'h77;
    cycle();
    bus.out_ready = 0; rdata1 = 32'h99;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("bp_op1", bus.out_op1, 32'h77);
      check("bp_ready", obs_ready, 0);
      check("bp_valid", bus.out_valid, 1);
    end
    flush = 1; bus.in_raddr1 = 7;
    t_we[0] = 1; t_addr[0] = 7; t_pend[0] = 1;
    cycle();
    check("fl_valid", bus.out_valid, 0);
    check("fl_stall", obs_stall, 0);
    check("fl_ready", obs_ready, 0);
    check("fl_hold_op1", bus.out_op1, 32'h77);

    // Reset mid-operation
    set_idle();
    bus.in_valid = 1; bus.in_re1 = 1; bus.in_raddr1 = 3; rdata1 = 32'h44;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    check("rstmid_valid", bus.out_valid, 0);
    check("rstmid_op1", bus.out_op1, 0);

    // Four hazard cycles
`ifdef ID_PERF_CNT_EN
    check("perf_rst", perf_stall, 0);
`endif
    set_idle();
    bus.in_valid = 1; bus.in_re2 = 1; bus.in_raddr2 = 7;
    t_we[0] = 1; t_addr[0] = 7; t_pend[0] = 1;
    for (int c = 0; c < 4; c++) cycle();
`ifdef ID_PERF_CNT_EN
    check("perf_four", perf_stall, 4);
`endif

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Registered ID/EX operand-resolution stage: takes decoded fields from the decoder, resolves rs1/rs2 values through a parametrised forwarding network, and holds them in the ID/EX pipeline register.
- Detects load-use hazards, where a forwarding source has a destination match but no data yet, and stalls upstream.
- Uses a valid/ready handshake on both sides and accepts a branch flush.

Parameters:
- XLEN, 32, data/address width
- REG_AW, 5, register address width
- NUM_FWD, 2, number of forwarding sources (≥1); index 0 = youngest (EX), highest priority
- CTRL_W, 16, width of opaque control bundle (aluop/alusel/mem_length packed by decoder)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_re1, in_re2  in  1 each  operand read enables
- in_raddr1, in_raddr2  in  REG_AW each  source registers
- in_imm  in  XLEN  immediate
- in_ctrl  in  CTRL_W  control bundle
- in_rd  in  REG_AW  destination register
- in_rd_e  in  1  destination write enable
- rdata1, rdata2  in  XLEN each  register-file read data (same cycle)
- fwd_we  in  NUM_FWD  per-source write enable
- fwd_waddr  in  NUM_FWD*REG_AW  per-source destination, source i at [i*REG_AW +: REG_AW]
- fwd_wdata  in  NUM_FWD*XLEN  per-source data
- fwd_pend  in  NUM_FWD  source i data not yet available (load in flight)
- flush  in  1  branch mispredict; kill stage contents
- out_valid  out  1  ID/EX register holds valid instruction
- out_ready  in  1  EX accepts
- out_pc, out_op1, out_op2, out_imm  out  XLEN each
- out_ctrl  out  CTRL_W
- out_rd  out  REG_AW
- out_rd_e  out  1
- stall_o  out  1  load-use stall this cycle

Behaviour:
- Operand resolve (combinational), per operand k:
  - re_k=0: op1=0; op2=in_imm.
  - raddr_k=0: value 0, never hazards.
  - Otherwise scan i=0..NUM_FWD-1. First i with fwd_we[i] && fwd_waddr[i]==raddr_k wins.
  - A source with fwd_waddr[i]==0 never matches.
  - Winner with fwd_pend[i]=1 sets hazard_k; value is don't-care.
  - Winner without pend supplies fwd_wdata[i]. No match gives rdata_k.
- hazard = in_valid && (hazard_1 || hazard_2).
- stall_o = hazard && !flush.
- A pending older source shadowed by a younger non-pending match does not hazard (youngest wins).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- fire = in_valid && in_ready.
- States (out_valid):
  - EMPTY → FULL on fire.
  - FULL stays FULL on fire (re-load).
  - FULL → EMPTY when out_ready && !fire (bubble insertion during hazard).
  - FULL holds all outputs unchanged when !out_ready.
  - flush (highest priority): next state EMPTY regardless of fire/out_ready; input that cycle is dropped (in_ready=0).
- Latency 1 cycle in_valid→out_valid. Throughput 1/cycle with no hazard.
- Output data registers load only on fire; they are not cleared on bubble or flush (only out_valid drops).
- rst: out_valid=0; all out_* data=0; counters=0. Reset mid-operation discards the held instruction. stall_o and in_ready are combinational and follow inputs after reset.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- Defined: adds outputs perf_stall[31:0] and perf_flush[31:0].
  - perf_stall increments each cycle stall_o=1.
  - perf_flush increments each cycle flush=1 && (out_valid || in_valid).
  - Both wrap at 2^32 → 0 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- No-hazard pipe:
  - Stimulus: in_valid=1 every cycle, re1=re2=1, raddr1=3, raddr2=4, rdata1=0x11, rdata2=0x22, no fwd_we, out_ready=1.
  - Response: out_op1=0x11, out_op2=0x22 one cycle later, out_valid continuous, stall_o=0.
- Priority forwarding:
  - Stimulus: NUM_FWD=2; fwd0 (we, addr 5, data 0xAAAA), fwd1 (we, addr 5, data 0xBBBB); raddr1=5.
  - Response: out_op1=0xAAAA. With fwd0 we=0: 0xBBBB.
- Load-use:
  - Stimulus: fwd0 we=1, addr 7, pend=1; raddr2=7, re2=1; out_ready=1.
  - Response: stall_o=1, in_ready=0, out_valid=0 next cycle (bubble).
  - Then drop pend, data 0x55: next cycle out_op2=0x55, out_valid=1.
- x0 / re=0:
  - Stimulus: raddr1=0, fwd0 we=1, addr 0, pend=1, data 0x9.
  - Response: out_op1=0, no stall.
  - Stimulus: re2=0, in_imm=0xFFFF_F800.
  - Response: out_op2=0xFFFF_F800.
- Backpressure + flush:
  - Stimulus: out_valid=1, out_ready=0 for 3 cycles.
  - Response: outputs stable, in_ready=0.
  - Stimulus: flush=1 with in_valid=1.
  - Response: out_valid=0 next cycle, input dropped, stall_o=0 even if hazard.
- Reset mid-op:
  - Stimulus: out_valid=1, rst=1 for one cycle.
  - Response: out_valid=0, out_op1=0.
  - ID_PERF_CNT_EN: perf_stall=0 after reset; equals 4 after 4 hazard cycles.
